// File: rtl/full_adder_behavioral.sv
// rtl/full_adder_behavioral.sv - 1-bit full adder with combinational and registered bit-serial paths
// Optional statistics counters are enabled by defining FA_STATS_EN.
module full_adder_behavioral #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  input  logic             in_valid,
  input  logic             serial_mode,
  input  logic             first_bit,
  output logic             sum_q,
  output logic             cout_q,
  output logic             out_valid,
`ifdef FA_STATS_EN
  output logic [CNT_W-1:0] add_count,
  output logic [CNT_W-1:0] carry_count,
`endif
  output logic             carry_state
);

  logic cin_eff;
  logic sum_d;
  logic cout_d;
  logic carry_q;

  // Combinational leaf-cell result; independent of clock, reset and mode inputs
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

  // Registered-path carry select and next-state result
  always_comb begin
    cin_eff = (serial_mode && !first_bit) ? carry_q : cin;
    sum_d   = a ^ b ^ cin_eff;
    cout_d  = (a & b) | (a & cin_eff) | (b & cin_eff);
  end

  // Result registers and serial carry chain; reset overrides capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= 1'b0;
      cout_q    <= 1'b0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        cout_q  <= cout_d;
        carry_q <= cout_d;
      end
    end
  end

  assign carry_state = carry_q;

`ifdef FA_STATS_EN
  logic [CNT_W-1:0] add_cnt_q;
  logic [CNT_W-1:0] carry_cnt_q;

  // Saturating counters of accepted adds and of accepted adds producing a carry
  always_ff @(posedge clk) begin
    if (rst) begin
      add_cnt_q   <= '0;
      carry_cnt_q <= '0;
    end else if (in_valid) begin
      if (add_cnt_q != {CNT_W{1'b1}}) begin
        add_cnt_q <= add_cnt_q + 1'b1;
      end
      if (cout_d && (carry_cnt_q != {CNT_W{1'b1}})) begin
        carry_cnt_q <= carry_cnt_q + 1'b1;
      end
    end
  end

  assign add_count   = add_cnt_q;
  assign carry_count = carry_cnt_q;
`endif

endmodule

// File: tb/tb_full_adder_behavioral.sv
// tb/tb_full_adder_behavioral.sv - self-checking scoreboard bench for full_adder_behavioral
module tb_full_adder_behavioral;

  logic clk = 1'b0;
  logic rst, a, b, cin, in_valid, serial_mode, first_bit;
  logic sum, cout, sum_q, cout_q, out_valid, carry_state;
`ifdef FA_STATS_EN
  logic [15:0] add_count, carry_count;
  logic [3:0]  add_count4, carry_count4;
  logic        s4, c4, sq4, cq4, ov4, cs4;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic       model_carry = 1'b0;
  logic [2:0] exp_q[$];
  logic [2:0] e;
  logic [2:0] last;

  always #5 clk = ~clk;

  full_adder_behavioral dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .in_valid(in_valid), .serial_mode(serial_mode), .first_bit(first_bit),
    .sum_q(sum_q), .cout_q(cout_q), .out_valid(out_valid),
`ifdef FA_STATS_EN
    .add_count(add_count), .carry_count(carry_count),
`endif
    .carry_state(carry_state)
  );

`ifdef FA_STATS_EN
  full_adder_behavioral #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(s4), .cout(c4),
    .in_valid(in_valid), .serial_mode(serial_mode), .first_bit(first_bit),
    .sum_q(sq4), .cout_q(cq4), .out_valid(ov4),
    .add_count(add_count4), .carry_count(carry_count4),
    .carry_state(cs4)
  );
`endif

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one set of inputs; when an add is accepted, push {sum,cout,carry} from an arithmetic model
  task automatic drive(input logic r, input logic iv, input logic ai, input logic bi,
                       input logic ci, input logic sm, input logic fb);
    logic [1:0] t;
    logic       ce;
    rst = r; in_valid = iv; a = ai; b = bi; cin = ci; serial_mode = sm; first_bit = fb;
    if (r) begin
      model_carry = 1'b0;
    end else if (iv) begin
      ce = (sm && !fb) ? model_carry : ci;
      t  = 2'(ai) + 2'(bi) + 2'(ce);
      model_carry = t[1];
      exp_q.push_back({t[0], t[1], t[1]});
    end
  endtask

  task automatic test_comb();
    logic [15:0] tt;
    tt = 16'b11_01_01_10_01_10_10_00;
    rst = 1'b0; in_valid = 1'b0; serial_mode = 1'b1; first_bit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #10;
      n_cmp++;
      if ({sum, cout} !== tt[2*i +: 2]) begin
        n_bad++;
        $display("FAIL comb abc=%03b: got s/c=%b%b want %b", 3'(i), sum, cout, tt[2*i +: 2]);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    e = exp_q.pop_front();
    n_cmp++;
    if ({sum_q, cout_q, carry_state, out_valid} !== {e, 1'b1}) begin
      n_bad++;
      $display("FAIL preset_add: got %b%b%b%b want %b1", sum_q, cout_q, carry_state, out_valid, e);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    n_cmp++;
    if ({sum_q, cout_q, out_valid, carry_state} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset: got sq/cq/ov/cs=%b%b%b%b want 0000", sum_q, cout_q, out_valid, carry_state);
    end
  endtask

  task automatic test_parallel();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL par_valid: got ov=%b want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({sum_q, cout_q} !== 2'b01 || {sum_q, cout_q, carry_state} !== e) begin
        n_bad++;
        $display("FAIL par_result: got %b%b%b want %b (sq=0 cq=1)", sum_q, cout_q, carry_state, e);
      end
    end
    last = {sum_q, cout_q, carry_state};
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    n_cmp++;
    if ({out_valid, sum_q, cout_q, carry_state} !== {1'b0, last}) begin
      n_bad++;
      $display("FAIL par_hold: got ov=%b %b%b%b want 0 %b", out_valid, sum_q, cout_q, carry_state, last);
    end
    // first_bit is ignored in parallel mode: cin=0 is used even though carry is set
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    n_cmp++;
    if ({out_valid, sum_q, cout_q, carry_state} !== {1'b1, e} || e !== 3'b100) begin
      n_bad++;
      $display("FAIL par_fb_ignored: got %b %b%b%b want 1 %b", out_valid, sum_q, cout_q, carry_state, e);
    end
  endtask

  task automatic test_serial();
    logic [3:0] av, bv, res;
    logic [3:0] want_s;
    av = 4'b0111; bv = 4'b0101; want_s = 4'b1100;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, av[i], bv[i], 1'b0, 1'b1, (i == 0));
      cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL ser_valid bit%0d: got ov=%b want 1", i, out_valid);
      end else begin
        e = exp_q.pop_front();
        res[i] = sum_q;
        n_cmp++;
        if ({sum_q, cout_q, carry_state} !== e || sum_q !== want_s[i]) begin
          n_bad++;
          $display("FAIL ser_bit%0d: got %b%b%b want %b", i, sum_q, cout_q, carry_state, e);
        end
      end
    end
    n_cmp++;
    if ({cout_q, res} !== 5'd12) begin
      n_bad++;
      $display("FAIL ser_total: got %0d want 12", {cout_q, res});
    end
  endtask

  task automatic test_serial_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_cmp++;
    if (carry_state !== 1'b1 || {sum_q, cout_q, carry_state} !== e) begin
      n_bad++;
      $display("FAIL sr_pre: got %b%b%b want %b (cs=1)", sum_q, cout_q, carry_state, e);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    n_cmp++;
    if (carry_state !== 1'b0) begin
      n_bad++;
      $display("FAIL sr_clear: got cs=%b want 0", carry_state);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    e = exp_q.pop_front();
    n_cmp++;
    if ({out_valid, sum_q, cout_q} !== 3'b101 || {sum_q, cout_q, carry_state} !== e) begin
      n_bad++;
      $display("FAIL sr_next: got ov=%b sq=%b cq=%b want 1 0 1", out_valid, sum_q, cout_q);
    end
  endtask

  task automatic test_back_to_back();
    int pend;
    for (int i = 0; i < 40; i++) begin
      pend = exp_q.size();
      drive(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      if (rst) exp_q.delete();
      cycle();
      n_cmp++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_bad++;
        $display("FAIL b2b_valid[%0d]: got ov=%b want %b", i, out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({sum_q, cout_q, carry_state} !== e) begin
          n_bad++;
          $display("FAIL b2b_result[%0d]: got %b%b%b want %b", i, sum_q, cout_q, carry_state, e);
        end
      end
    end
  endtask

`ifdef FA_STATS_EN
  task automatic test_stats();
    logic [4:0] carries;
    carries = 5'b10101;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, (i < 5) ? carries[i] : 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      void'(exp_q.pop_front());
      if (i == 4) begin
        n_cmp++;
        if (add_count !== 16'd5 || carry_count !== 16'd3) begin
          n_bad++;
          $display("FAIL stats5: got add=%0d carry=%0d want 5 3", add_count, carry_count);
        end
      end
    end
    n_cmp++;
    if (add_count4 !== 4'd15 || add_count !== 16'd20) begin
      n_bad++;
      $display("FAIL stats_sat: got add4=%0d add=%0d want 15 20", add_count4, add_count);
    end
  endtask
`endif

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    test_comb();
    test_reset();
    test_parallel();
    test_serial();
    test_serial_reset();
    test_back_to_back();
`ifdef FA_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
